seq_frame_tx: RTL

- Serial framer/transmitter for the "1011" sync-detect link.
- Accepts a DATA_W-bit word over valid/ready and emits it one bit per bit-period on `x`.
- Each frame is sync word 1011, then the payload MSB-first with zero-stuffing, then one guard 0.
- The stuffing and guard bit guarantee that an overlapping 1011 Moore detector at the far end sees exactly one match per frame, at the sync word.

---
 rtl/seq_link_pkg.sv | 26 ++
 rtl/seq_stuff_check.sv | 29 ++
 rtl/seq_frame_tx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seq_link_pkg.sv
// Shared definitions for the "1011" sync-detect serial link.
// The framer and the far-end receiver both import this package.
package seq_link_pkg;

    localparam int SYNC_W = 4;
    localparam logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011;

    // Three-bit emitted history that forces an inserted 0 ahead of the next payload bit.
    localparam logic [2:0] STUFF_TRIG = 3'b101;

    // Each state is named for the bit currently driven on the line.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        PAYLOAD = 3'd2,
        STUFF   = 3'd3,
        GUARD   = 3'd4
    } state_t;

    // Observation bundle so checkers can follow the framer without probing internals.
    typedef struct packed {
        state_t     state;
        logic [2:0] history;
    } tx_dbg_t;

endpackage

// File: rtl/seq_stuff_check.sv
// Three-bit emitted-bit history with a 101 match flag.
// The flag looks at the two most recent history bits plus the bit on the line now,
// so the framer can decide on stuffing at the same bit edge that retires that bit.
module seq_stuff_check
    import seq_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       bit_in,
    output logic [2:0] history,
    output logic       match
);

    // Shift the bit being retired into the history on every enabled edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            history <= 3'b000;
        end else if (en) begin
            history <= {history[1:0], bit_in};
        end
    end

    // Last three emitted bits, oldest first, compared against the trigger pattern.
    always_comb begin
        match = ({history[1:0], bit_in} == STUFF_TRIG);
    end

endmodule

// File: rtl/seq_frame_tx.sv
// Serial framer for the 1011 sync-detect link.
// Frame on x: sync 1011, payload MSB-first with a 0 stuffed after every 101
// emitted run, then one guard 0. All line activity advances only on bit edges
// (rising clk with bit_en=1 and rst=1).
//
// Handshake: a word transfers on a rising clk where in_valid and in_ready are
// both 1. in_ready is only high on bit edges while the line is idle or sending
// the guard bit, so the source must hold in_valid/in_data stable until it sees
// the transfer; in_valid during the rest of a frame is simply not taken.
module seq_frame_tx
    import seq_link_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              x,
    output logic              busy,
    output logic              frame_done,
    output tx_dbg_t           dbg
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W);

    state_t            state, state_n;
    logic [1:0]        idx, idx_n;
    logic [CW-1:0]     pay_cnt, pay_cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              x_n;
    logic              done_n;
    logic              decide;
    logic [2:0]        history;
    logic              stuff_hit;

    seq_stuff_check u_stuff (
        .clk     (clk),
        .rst     (rst),
        .en      (bit_en),
        .bit_in  (x),
        .history (history),
        .match   (stuff_hit)
    );

    // Ready only while the line is idle or on its guard bit, and only on a bit edge.
    always_comb begin
        in_ready = ((state == IDLE) || (state == GUARD)) && bit_en && rst;
    end

    // Next line bit and next state; the payload decision is shared by SYNC idx 3, PAYLOAD and STUFF.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        pay_cnt_n = pay_cnt;
        shreg_n   = shreg;
        x_n       = x;
        done_n    = 1'b0;
        decide    = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n   = SYNC;
                    idx_n     = 2'd0;
                    pay_cnt_n = '0;
                    shreg_n   = in_data;
                    x_n       = SYNC_PATTERN[SYNC_W-1];
                end else begin
                    x_n = 1'b0;
                end
            end
            SYNC: begin
                if (idx != 2'd3) begin
                    idx_n = idx + 2'd1;
                    x_n   = SYNC_PATTERN[2'd2 - idx];
                end else begin
                    decide = 1'b1;
                end
            end
            PAYLOAD: decide = 1'b1;
            STUFF:   decide = 1'b1;
            GUARD: begin
                done_n = 1'b1;
                if (in_valid) begin
                    state_n   = SYNC;
                    idx_n     = 2'd0;
                    pay_cnt_n = '0;
                    shreg_n   = in_data;
                    x_n       = SYNC_PATTERN[SYNC_W-1];
                end else begin
                    state_n = IDLE;
                    x_n     = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                x_n     = 1'b0;
            end
        endcase

        if (decide) begin
            if (pay_cnt == CNT_MAX) begin
                state_n = GUARD;
                x_n     = 1'b0;
            end else if (stuff_hit) begin
                state_n = STUFF;
                x_n     = 1'b0;
            end else begin
                state_n   = PAYLOAD;
                x_n       = shreg[DATA_W-1];
                shreg_n   = {shreg[DATA_W-2:0], 1'b0};
                pay_cnt_n = pay_cnt + CW'(1);
            end
        end
    end

    // Line state register: advances on bit edges, frame_done lasts a single clk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            pay_cnt    <= '0;
            shreg      <= '0;
            x          <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (bit_en) begin
                state      <= state_n;
                idx        <= idx_n;
                pay_cnt    <= pay_cnt_n;
                shreg      <= shreg_n;
                x          <= x_n;
                busy       <= (state_n != IDLE);
                frame_done <= done_n;
            end
        end
    end

    // Expose the FSM state and stuffing history for observation.
    always_comb begin
        dbg.state   = state;
        dbg.history = history;
    end

endmodule
